// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter_if
// Description : Bundle of the two requester ports, the data-memory port and
//               the status outputs of the data-memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_port_arbiter_if;
    // Port A (CPU load/store unit)
    logic        a_req;
    logic [2:0]  a_op;
    logic [8:0]  a_addr;
    logic [31:0] a_wdata;
    logic        a_ack;
    logic        a_err;
    logic [31:0] a_rdata;
    // Port B (debug loader / DMA)
    logic        b_req;
    logic [2:0]  b_op;
    logic [8:0]  b_addr;
    logic [31:0] b_wdata;
    logic        b_ack;
    logic        b_err;
    logic [31:0] b_rdata;
    // Data-memory side
    logic        dmem_ena;
    logic        dmem_r;
    logic        dmem_w;
    logic [6:0]  dmem_addr;
    logic [31:0] dmem_data_in;
    logic [31:0] dmem_data_out;
    logic        is_sw, is_lw, is_sb, is_sh, is_lb, is_lh, is_lbu, is_lhu;
    logic [1:0]  b_r;
    logic [1:0]  h_r;
    // Status
    logic        busy;
    logic        owner;

    // Arbiter side
    modport slave (
        input  a_req, a_op, a_addr, a_wdata,
        output a_ack, a_err, a_rdata,
        input  b_req, b_op, b_addr, b_wdata,
        output b_ack, b_err, b_rdata,
        output dmem_ena, dmem_r, dmem_w, dmem_addr, dmem_data_in,
        input  dmem_data_out,
        output is_sw, is_lw, is_sb, is_sh, is_lb, is_lh, is_lbu, is_lhu,
        output b_r, h_r, busy, owner
    );

    // Requesters plus memory side
    modport master (
        output a_req, a_op, a_addr, a_wdata,
        input  a_ack, a_err, a_rdata,
        output b_req, b_op, b_addr, b_wdata,
        input  b_ack, b_err, b_rdata,
        input  dmem_ena, dmem_r, dmem_w, dmem_addr, dmem_data_in,
        output dmem_data_out,
        input  is_sw, is_lw, is_sb, is_sh, is_lb, is_lh, is_lbu, is_lhu,
        input  b_r, h_r, busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Round-robin two-port access controller for the data memory.
//               Each access runs IDLE -> ACCESS -> DONE; read data and error
//               status are returned registered with a one-cycle ack.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int unsigned DEPTH = 32
) (
    input logic              clk,
    input logic              rst,
    dmem_port_arbiter_if.slave bus
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;

    localparam logic [2:0] c_op_lw  = 3'd0;
    localparam logic [2:0] c_op_lb  = 3'd1;
    localparam logic [2:0] c_op_lbu = 3'd2;
    localparam logic [2:0] c_op_lh  = 3'd3;
    localparam logic [2:0] c_op_lhu = 3'd4;
    localparam logic [2:0] c_op_sw  = 3'd5;
    localparam logic [2:0] c_op_sb  = 3'd6;
    localparam logic [2:0] c_op_sh  = 3'd7;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        r_last_b;      // 1 when port B was served last
    logic        r_owner;
    logic [2:0]  r_op;
    logic [8:0]  r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic        r_a_ack, r_a_err, r_b_ack, r_b_err;
    logic [31:0] r_a_rdata, r_b_rdata;

    logic        w_any_req;
    logic        w_grant_b;
    logic [2:0]  w_sel_op;
    logic [8:0]  w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_sel_err;
    logic        w_is_load;
    logic        w_mem_go;

    // Winner selection and request mux; on a tie the port not served last wins.
    always_comb begin
        w_any_req   = bus.a_req | bus.b_req;
        w_grant_b   = bus.b_req & (~bus.a_req | ~r_last_b);
        w_sel_op    = w_grant_b ? bus.b_op    : bus.a_op;
        w_sel_addr  = w_grant_b ? bus.b_addr  : bus.a_addr;
        w_sel_wdata = w_grant_b ? bus.b_wdata : bus.a_wdata;
    end

    // Alignment and range check of the winning request, evaluated at latch time.
    always_comb begin
        w_sel_err = 1'b0;
        case (w_sel_op)
            c_op_lw, c_op_sw:           w_sel_err = (w_sel_addr[1:0] != 2'b00);
            c_op_lh, c_op_lhu, c_op_sh: w_sel_err = w_sel_addr[0];
            default:                    w_sel_err = 1'b0;
        endcase
        if ({25'd0, w_sel_addr[8:2]} >= DEPTH) begin
            w_sel_err = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one ACCESS cycle and one DONE cycle per granted request.
    always_comb begin
        w_state_next = c_st_idle;
        case (r_state)
            c_st_idle:   w_state_next = w_any_req ? c_st_access : c_st_idle;
            c_st_access: w_state_next = c_st_done;
            c_st_done:   w_state_next = c_st_idle;
            default:     w_state_next = c_st_idle;
        endcase
    end

    // Latch the winner's request so late input changes cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_op    <= 3'd0;
            r_addr  <= 9'd0;
            r_wdata <= 32'd0;
            r_err   <= 1'b0;
        end else if ((r_state == c_st_idle) && w_any_req) begin
            r_owner <= w_grant_b;
            r_op    <= w_sel_op;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_err   <= w_sel_err;
        end
    end

    // Response registers: ack/err/rdata raised at the end of ACCESS, ack and
    // err cleared at the end of DONE when the round-robin pointer advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_ack   <= 1'b0;
            r_a_err   <= 1'b0;
            r_a_rdata <= 32'd0;
            r_b_ack   <= 1'b0;
            r_b_err   <= 1'b0;
            r_b_rdata <= 32'd0;
            r_last_b  <= 1'b1;
        end else if (r_state == c_st_access) begin
            if (r_owner) begin
                r_b_ack   <= 1'b1;
                r_b_err   <= r_err;
                r_b_rdata <= (w_is_load && !r_err) ? bus.dmem_data_out : 32'd0;
            end else begin
                r_a_ack   <= 1'b1;
                r_a_err   <= r_err;
                r_a_rdata <= (w_is_load && !r_err) ? bus.dmem_data_out : 32'd0;
            end
        end else if (r_state == c_st_done) begin
            r_a_ack  <= 1'b0;
            r_a_err  <= 1'b0;
            r_b_ack  <= 1'b0;
            r_b_err  <= 1'b0;
            r_last_b <= r_owner;
        end
    end

    // Memory-side decode from state and latched fields only; an erroring
    // access keeps every strobe low.
    always_comb begin
        w_is_load        = (r_op <= c_op_lhu);
        w_mem_go         = (r_state == c_st_access) && !r_err;
        bus.dmem_ena     = w_mem_go;
        bus.dmem_r       = w_mem_go & w_is_load;
        bus.dmem_w       = w_mem_go & ~w_is_load;
        bus.dmem_addr    = w_mem_go ? r_addr[8:2] : 7'd0;
        bus.dmem_data_in = w_mem_go ? r_wdata : 32'd0;
        bus.b_r          = w_mem_go ? r_addr[1:0] : 2'd0;
        bus.h_r          = w_mem_go ? r_addr[1:0] : 2'd0;
        bus.is_lw        = w_mem_go && (r_op == c_op_lw);
        bus.is_lb        = w_mem_go && (r_op == c_op_lb);
        bus.is_lbu       = w_mem_go && (r_op == c_op_lbu);
        bus.is_lh        = w_mem_go && (r_op == c_op_lh);
        bus.is_lhu       = w_mem_go && (r_op == c_op_lhu);
        bus.is_sw        = w_mem_go && (r_op == c_op_sw);
        bus.is_sb        = w_mem_go && (r_op == c_op_sb);
        bus.is_sh        = w_mem_go && (r_op == c_op_sh);
    end

    // Port responses and status.
    always_comb begin
        bus.a_ack   = r_a_ack;
        bus.a_err   = r_a_err;
        bus.a_rdata = r_a_rdata;
        bus.b_ack   = r_b_ack;
        bus.b_err   = r_b_err;
        bus.b_rdata = r_b_rdata;
        bus.busy    = (r_state != c_st_idle);
        bus.owner   = r_owner;
    end

endmodule
`default_nettype wire
